// File: rtl/excp_redirect_ctrl.sv
// excp_redirect_ctrl: recovery sequencer for WB-stage exceptions and ERET.
// An accepted trigger flushes the pipe (first flush cycle is the trigger
// cycle itself), then holds a redirect to IF until IF accepts it. ID issue is
// blocked for the whole sequence. Also produces the registered masked
// interrupt request that ID uses to tag the next instruction.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ws_ex_i/ws_eret_i   qualified WB exception / eret pulses
//   ws_excode_i         WB excode, recorded on exception accept
//   cp0_status_i        CP0 Status (IE=0, EXL=1, IM=15:8)
//   cp0_cause_i         CP0 Cause (IP=15:8)
//   cp0_epc_i           CP0 EPC, eret target
//   redirect_ready_i    IF takes the redirect this cycle
//   flush_o             flush all stage valids
//   redirect_valid_o    redirect_pc_o is valid
//   redirect_pc_o       new fetch PC
//   issue_block_o       ID must not issue
//   int_req_o           pending enabled interrupt
//   last_excode_o       excode of last accepted exception
//   ex_cnt_o/eret_cnt_o saturating accepted-event counters
//   err_o               sticky: trigger arrived while busy
module excp_redirect_ctrl #(
  parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ws_ex_i,
  input  logic             ws_eret_i,
  input  logic [4:0]       ws_excode_i,
  input  logic [31:0]      cp0_status_i,
  input  logic [31:0]      cp0_cause_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             redirect_ready_i,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             issue_block_o,
  output logic             int_req_o,
  output logic [4:0]       last_excode_o,
  output logic [CNT_W-1:0] ex_cnt_o,
  output logic [CNT_W-1:0] eret_cnt_o,
  output logic             err_o
);

  // Down-counter covers the flush cycles after the trigger cycle.
  localparam int unsigned    FC_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 2) ? FC_W'(FLUSH_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [31:0]       target_q, target_d;
  logic [CNT_W-1:0]  ex_cnt_q, ex_cnt_d;
  logic [CNT_W-1:0]  eret_cnt_q, eret_cnt_d;
  logic [4:0]        excode_q, excode_d;
  logic              err_q, err_d;
  logic              int_req_q, int_req_d;

  logic trigger_c;
  logic accept_c;
  logic flush_c;
  logic block_c;
  logic int_raw_c;
  logic unused_c;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      target_q   <= '0;
      ex_cnt_q   <= '0;
      eret_cnt_q <= '0;
      excode_q   <= '0;
      err_q      <= 1'b0;
      int_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      target_q   <= target_d;
      ex_cnt_q   <= ex_cnt_d;
      eret_cnt_q <= eret_cnt_d;
      excode_q   <= excode_d;
      err_q      <= err_d;
      int_req_q  <= int_req_d;
    end
  end

  // Next-state logic and combinational flush/block.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    target_d   = target_q;
    ex_cnt_d   = ex_cnt_q;
    eret_cnt_d = eret_cnt_q;
    excode_d   = excode_q;
    err_d      = err_q;

    trigger_c = ws_ex_i | ws_eret_i;
    // Gated with reset so every output reads 0 while reset is held.
    accept_c  = (state_q == IDLE) & trigger_c & ~reset;
    flush_c   = accept_c | (state_q == FLUSH);
    block_c   = flush_c | (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          // Exception wins over eret when both are presented.
          target_d = ws_ex_i ? EX_ENTRY : cp0_epc_i;
          fcnt_d   = FC_LOAD;
          state_d  = (FLUSH_CYCLES > 1) ? FLUSH : REDIR;
          if (ws_ex_i) begin
            excode_d = ws_excode_i;
            if (ex_cnt_q != '1) ex_cnt_d = ex_cnt_q + CNT_W'(1);
          end else if (eret_cnt_q != '1) begin
            eret_cnt_d = eret_cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = REDIR;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      REDIR: begin
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A trigger while busy is dropped but remembered.
    if (trigger_c && (state_q != IDLE)) err_d = 1'b1;

    int_raw_c = (|(cp0_cause_i[15:8] & cp0_status_i[15:8])) & cp0_status_i[0] & ~cp0_status_i[1];
    int_req_d = int_raw_c & ~block_c;
  end

  assign flush_o          = flush_c;
  assign issue_block_o    = block_c;
  assign redirect_valid_o = (state_q == REDIR);
  assign redirect_pc_o    = (state_q == REDIR) ? target_q : '0;
  assign int_req_o        = int_req_q & ~block_c;
  assign last_excode_o    = excode_q;
  assign ex_cnt_o         = ex_cnt_q;
  assign eret_cnt_o       = eret_cnt_q;
  assign err_o            = err_q;

  // CP0 fields not involved in the interrupt decision.
  assign unused_c = ^{cp0_status_i[31:16], cp0_status_i[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};

endmodule
